// File: rtl/gf2m_serial_multiplier_pkg.sv
// Shared definitions for the serial GF(2^M) multiplier: FSM state encoding,
// default field parameters and the latency helper.
// Optional build macro: GF2M_MUL_DIGIT2_EN (two multiplier bits per cycle).
package gf2m_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gf2m_state_e;

  localparam int         DEFAULT_M    = 3;
  localparam logic [3:0] DEFAULT_POLY = 4'b1101;  // x^3 + x^2 + 1
  localparam logic [8:0] AES_POLY     = 9'h11B;   // x^8 + x^4 + x^3 + x + 1

`ifdef GF2M_MUL_DIGIT2_EN
  localparam bit DIGIT2 = 1'b1;
`else
  localparam bit DIGIT2 = 1'b0;
`endif

  // Number of CALC cycles for field degree m; digit mode halves it (rounded up).
  function automatic int gf2m_latency(input int m, input bit digit2);
    return digit2 ? (m + 1) / 2 : m;
  endfunction

endpackage

// File: rtl/gf2m_serial_multiplier_if.sv
// Operand/result handshake bundle for gf2m_serial_multiplier.
// master = producer/consumer side, slave = multiplier side.
interface gf2m_serial_multiplier_if
  import gf2m_pkg::*;
#(
  parameter int M = DEFAULT_M
);
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] A;
  logic [M-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] Z;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Z
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Z
  );
endinterface

// File: rtl/gf2m_serial_multiplier_step.sv
// One MSB-first shift-and-add step: acc_next = (acc * x mod POLY) ^ (b_bit ? a : 0).
// Purely combinational; chained twice when two bits are processed per cycle.
module gf2m_mul_step #(
  parameter int         M    = 3,
  parameter logic [M:0] POLY = 4'b1101
) (
  input  logic [M-1:0] acc,
  input  logic [M-1:0] a,
  input  logic         b_bit,
  output logic [M-1:0] acc_next
);
  logic [M-1:0] shifted;

  // Multiply by x, fold the overflowing x^M term back in, then add a if selected.
  always_comb begin
    shifted = {acc[M-2:0], 1'b0};
    if (acc[M-1]) begin
      shifted = shifted ^ POLY[M-1:0];
    end
    acc_next = b_bit ? (shifted ^ a) : shifted;
  end
endmodule

// File: rtl/gf2m_serial_multiplier.sv
// Sequential GF(2^M) multiplier, Z = A*B mod POLY, MSB-first over B.
// Valid/ready on both sides; all outputs come straight from flops.
// Optional build macro: GF2M_MUL_DIGIT2_EN (two multiplier bits per cycle).
module gf2m_serial_multiplier
  import gf2m_pkg::*;
#(
  parameter int         M    = DEFAULT_M,
  parameter logic [M:0] POLY = (M+1)'(DEFAULT_POLY)
) (
  input logic                    clk,
  input logic                    rst,
  gf2m_serial_multiplier_if.slave bus
);
  localparam int CW  = $clog2(M);
  localparam int LAT = gf2m_latency(M, DIGIT2);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_DONE = DONE;

  // A field polynomial without the x^M term is not a degree-M field.
  if (POLY[M] != 1'b1) begin : g_poly_check
    $error("gf2m_serial_multiplier: POLY[M] must be 1");
  end

  logic [1:0]    state;
  logic [M-1:0]  a_reg;
  logic [M-1:0]  b_reg;
  logic [M-1:0]  acc;
  logic [M-1:0]  acc_next;
  logic [M-1:0]  z_reg;
  logic [CW-1:0] count;
  logic          in_ready_reg;
  logic          out_valid_reg;
  logic          bit_lo;

`ifdef GF2M_MUL_DIGIT2_EN
  logic          bit_hi;
  logic [M-1:0]  acc_mid;

  // Bit pair (2*count+1, 2*count); for odd M the top index falls off the
  // operand and reads as 0, so the first cycle effectively handles bit M-1 only.
  always_comb begin
    bit_hi = 1'b0;
    bit_lo = 1'b0;
    for (int i = 0; i < M; i++) begin
      if (i == 2 * int'(count) + 1) bit_hi = b_reg[i];
      if (i == 2 * int'(count))     bit_lo = b_reg[i];
    end
  end

  gf2m_mul_step #(.M(M), .POLY(POLY)) u_step_hi (
    .acc(acc), .a(a_reg), .b_bit(bit_hi), .acc_next(acc_mid)
  );
  gf2m_mul_step #(.M(M), .POLY(POLY)) u_step_lo (
    .acc(acc_mid), .a(a_reg), .b_bit(bit_lo), .acc_next(acc_next)
  );
`else
  // Select multiplier bit b_reg[count].
  always_comb begin
    bit_lo = 1'b0;
    for (int i = 0; i < M; i++) begin
      if (i == int'(count)) bit_lo = b_reg[i];
    end
  end

  gf2m_mul_step #(.M(M), .POLY(POLY)) u_step (
    .acc(acc), .a(a_reg), .b_bit(bit_lo), .acc_next(acc_next)
  );
`endif

  // Control FSM and datapath registers; reset abandons any product in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      acc           <= '0;
      count         <= '0;
      z_reg         <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            a_reg        <= bus.A;
            b_reg        <= bus.B;
            acc          <= '0;
            count        <= CW'(LAT - 1);
            in_ready_reg <= 1'b0;
            state        <= S_CALC;
          end
        end
        S_CALC: begin
          acc <= acc_next;
          if (count == '0) begin
            z_reg         <= acc_next;
            out_valid_reg <= 1'b1;
            state         <= S_DONE;
          end else begin
            count <= count - CW'(1);
          end
        end
        S_DONE: begin
          // in_ready only returns on the following edge, so no operand can
          // be taken in the same cycle as the result handshake.
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state         <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.Z         = z_reg;

endmodule

// File: doc/gf2m_serial_multiplier.md
# gf2m_serial_multiplier

Sequential, parametrised GF(2^M) multiplier, the successor to the fixed 3-bit combinational Mastrovito multiplier. It computes Z = A·B mod P(x) with an MSB-first shift-and-add datapath that handles one multiplier bit per cycle (two with the digit option). A valid/ready handshake sits on both the operand and the result side. It plugs into the field-arithmetic datapath wherever operand width exceeds what a flat combinational array should carry.

## Interface
- M, 3, field degree (operand/result width), M ≥ 2.
- POLY, 4'b1101, reduction polynomial, width M+1.
  - Default is x^3+x^2+1.
  - POLY[M] must be 1 (elaboration-time check).
  - Irreducibility is the integrator's responsibility.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands A, B presented.
- in_ready  output  1  block can accept operands.
- A  input  M  multiplicand.
- B  input  M  multiplier.
- out_valid  output  1  Z holds a completed product.
- out_ready  input  1  consumer accepts Z.
- Z  output  M  product A·B mod POLY.

## Operation
- FSM states: IDLE, CALC, DONE.
- Reset (async, any state) forces:
  - state = IDLE, in_ready = 1, out_valid = 0, Z = 0.
  - Internal a_reg, b_reg, acc and count cleared.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch A→a_reg and B→b_reg, clear acc, set count = M−1, go to CALC.
  - A and B are sampled only at acceptance; later changes on them are ignored.
- CALC, one step per cycle on bit b_reg[count]:
  - acc_next = (acc<<1) reduced by POLY, then XOR (b_reg[count] ? a_reg : 0).
  - Reduction: if acc[M−1] = 1, XOR the shifted value with POLY[M−1:0].
  - All arithmetic is carry-free, M bits wide.
  - After the step with count = 0: Z ← acc_next, state = DONE.
  - in_ready = 0 throughout.
- DONE:
  - out_valid = 1. Z is held stable until out_ready = 1.
  - On out_valid & out_ready: out_valid = 0, go to IDLE. Z keeps its last value.
  - No operand is accepted in the same cycle as the result handshake. Minimum issue interval is M+2 cycles.
- in_valid while busy: ignored (in_ready = 0). No queueing.
- A = 0 or B = 0 still runs the full M cycles and produces Z = 0. No early termination.

## Timing
- Operands accepted at rising edge T0.
- With the digit option off, out_valid rises after edge T0+M. First observable cycle is M cycles after acceptance.
- out_ready asserted combinationally in the first DONE cycle: out_valid drops after the next edge, and in_ready is high in the cycle after that edge.
- All outputs are registered. No combinational path from inputs to outputs.
- Reset asserted mid-CALC or in DONE: the result is discarded and the block is back in IDLE immediately. No spurious out_valid after reset release.

## Configuration
- GF2M_MUL_DIGIT2_EN defined:
  - CALC processes two multiplier bits per cycle by chaining two steps, highest bit first.
  - For odd M, the first CALC cycle processes only bit M−1.
  - Latency is ceil(M/2) cycles. count steps accordingly.
  - Results are identical to the undefined case.
- GF2M_MUL_DIGIT2_EN undefined: one bit per cycle, latency M.

## Structure
- Package gf2m_pkg holds:
  - The state enum {IDLE, CALC, DONE}.
  - Default M and POLY constants, plus AES_POLY = 9'h11B.
  - A constant function returning the latency for a given M and digit mode.
- Sub-module gf2m_mul_step:
  - Combinational single step: (acc, a, b_bit) → acc_next.
  - Parametrised by M and POLY.
  - Instantiated once, or twice in series under GF2M_MUL_DIGIT2_EN.

## Test plan
- M=3 defaults: A=3'b011, B=3'b101 → Z=3'b010; out_valid exactly 3 cycles after acceptance (2 with digit option).
- M=3, A=3'b100, B=3'b100 → Z=3'b111. All 64 (A,B) pairs checked exhaustively against a software GF(2^3) model.
- M=8, POLY=9'h11B: 0x57·0x83 → 0xC1; 0x57·0x13 → 0xFE; 0x00·0xFF → 0x00 after a full-length run.
- Backpressure: out_ready held low 10 cycles → Z and out_valid stable, in_ready = 0. Then out_ready=1 → IDLE. A second operand pair held valid throughout is accepted only in the IDLE cycle.
- Reset mid-CALC (count = 1): out_valid stays 0, Z = 0, in_ready = 1 in the cycle after rst asserts. A new operation after release gives the correct product.
- Run the operand-change test in both digit modes: A/B toggled during CALC does not affect Z. M=5 with GF2M_MUL_DIGIT2_EN gives latency 3.
